// File: rtl/cuckoo_pkg.sv
// Shared definitions for the cuckoo page-table stages: entry layout, walker
// state encoding, op encoding and the two-way hash functions.
package cuckoo_pkg;

  localparam int VPN_W   = 16;
  localparam int TAG_W   = 5;
  localparam int PPN_W   = 6;
  localparam int IDX_W   = 11;
  localparam int ADDR_W  = IDX_W + 1;        // way bit + index
  localparam int ENT_W   = 1 + TAG_W + PPN_W; // {valid, tag, ppn}
  localparam int VALID_B = ENT_W - 1;
  localparam int TAG_LSB = PPN_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD0, S_CHK0, S_RD1, S_CHK1, S_WR, S_RESP
  } state_e;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_INSERT = 1'b1
  } op_e;

  function automatic logic [TAG_W-1:0] vpn_tag(input logic [VPN_W-1:0] vpn);
    return vpn[VPN_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] hash_h0(input logic [VPN_W-1:0] vpn);
    return vpn[IDX_W-1:0];
  endfunction

  // Tag replicated across the index so entries sharing an h0 slot but with
  // different tags scatter to different way-1 slots.
  function automatic logic [IDX_W-1:0] hash_h1(input logic [VPN_W-1:0] vpn);
    logic [TAG_W-1:0] t;
    t = vpn_tag(vpn);
    return vpn[IDX_W-1:0] ^ {t, t, t[0]};
  endfunction

endpackage

// File: rtl/cuckoo_hash.sv
// Combinational slot computation for a VPN.
//   vpn_i   : virtual page number
//   tag_o   : tag stored in / compared against an entry
//   addr0_o : way-0 memory address {0, h0}
//   addr1_o : way-1 memory address {1, h1}
module cuckoo_hash
  import cuckoo_pkg::*;
(
  input  logic [15:0] vpn_i,
  output logic [4:0]  tag_o,
  output logic [11:0] addr0_o,
  output logic [11:0] addr1_o
);

  assign tag_o   = vpn_tag(vpn_i);
  assign addr0_o = {1'b0, hash_h0(vpn_i)};
  assign addr1_o = {1'b1, hash_h1(vpn_i)};

endmodule

// File: rtl/cuckoo_walker.sv
// Two-way cuckoo walk engine; sole master of the 4096 x 12 page-table memory.
// Sweeps the memory to zero after reset, then serves lookup/insert requests.
//   clk, rst            : clock, async active-high reset
//   req_*_i / req_ready_o : request channel (op, vpn, ppn)
//   resp_*_o / resp_ready_i : response channel (hit, ok, way, ppn)
//   mem_*               : single-cycle read/write port, read data one cycle late
module cuckoo_walker
  import cuckoo_pkg::*;
#(
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_op_i,
  input  logic [15:0] req_vpn_i,
  input  logic [5:0]  req_ppn_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_hit_o,
  output logic        resp_ok_o,
  output logic        resp_way_o,
  output logic [5:0]  resp_ppn_o,
  output logic [11:0] mem_addr_o,
  output logic [11:0] mem_wdata_o,
  input  logic [11:0] mem_rdata_i,
  output logic        mem_wr_en_o,
  output logic        mem_rd_en_o
);

  localparam state_e RST_STATE = INIT_ON_RESET ? S_INIT : S_IDLE;

  state_e            state_q, state_d;
  logic [11:0]       cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [15:0]       vpn_q, vpn_d;
  logic [5:0]        ppn_q, ppn_d;
  logic              w0e_q, w0e_d;   // way 0 was empty on this insert
  logic              hit_q, hit_d;
  logic              ok_q, ok_d;
  logic              way_q, way_d;   // also selects the WR target
  logic [5:0]        rppn_q, rppn_d;

  logic [4:0]        tag;
  logic [11:0]       addr0, addr1;
  entry_t            rd;
  logic              match;

  cuckoo_hash u_hash (
    .vpn_i   (vpn_q),
    .tag_o   (tag),
    .addr0_o (addr0),
    .addr1_o (addr1)
  );

  assign rd    = entry_t'(mem_rdata_i);
  assign match = rd.valid && (rd.tag == tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      op_q    <= OP_LOOKUP;
      vpn_q   <= '0;
      ppn_q   <= '0;
      w0e_q   <= 1'b0;
      hit_q   <= 1'b0;
      ok_q    <= 1'b0;
      way_q   <= 1'b0;
      rppn_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      vpn_q   <= vpn_d;
      ppn_q   <= ppn_d;
      w0e_q   <= w0e_d;
      hit_q   <= hit_d;
      ok_q    <= ok_d;
      way_q   <= way_d;
      rppn_q  <= rppn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    vpn_d   = vpn_q;
    ppn_d   = ppn_q;
    w0e_d   = w0e_q;
    hit_d   = hit_q;
    ok_d    = ok_q;
    way_d   = way_q;
    rppn_d  = rppn_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == ADDR_MAX) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid_i) begin
          op_d    = op_e'(req_op_i);
          vpn_d   = req_vpn_i;
          ppn_d   = req_ppn_i;
          w0e_d   = 1'b0;
          hit_d   = 1'b0;
          ok_d    = 1'b0;
          way_d   = 1'b0;
          rppn_d  = '0;
          state_d = S_RD0;
        end
      end
      S_RD0: state_d = S_CHK0;
      S_CHK0: begin
        if (op_q == OP_LOOKUP) begin
          if (match) begin
            hit_d   = 1'b1;
            ok_d    = 1'b1;
            way_d   = 1'b0;
            rppn_d  = rd.ppn;
            state_d = S_RESP;
          end else begin
            state_d = S_RD1;
          end
        end else if (match) begin
          hit_d   = 1'b1;
          way_d   = 1'b0;
          state_d = S_WR;
        end else begin
          w0e_d   = ~rd.valid;
          state_d = S_RD1;
        end
      end
      S_RD1: state_d = S_CHK1;
      S_CHK1: begin
        if (op_q == OP_LOOKUP) begin
          ok_d    = 1'b1;
          state_d = S_RESP;
          if (match) begin
            hit_d  = 1'b1;
            way_d  = 1'b1;
            rppn_d = rd.ppn;
          end
        end else if (match) begin
          hit_d   = 1'b1;
          way_d   = 1'b1;
          state_d = S_WR;
        end else if (w0e_q) begin
          way_d   = 1'b0;
          state_d = S_WR;
        end else if (!rd.valid) begin
          way_d   = 1'b1;
          state_d = S_WR;
        end else begin
          ok_d    = 1'b0;     // both ways hold other tags; no eviction
          state_d = S_RESP;
        end
      end
      S_WR: begin
        ok_d    = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: if (resp_ready_i) state_d = S_IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  // Memory port decoded straight from state so the sweep writes address 0
  // in the first cycle after reset release. The strobes that are live in the
  // reset state are masked by rst so they drop while reset is held.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wr_en_o = 1'b0;
    mem_rd_en_o = 1'b0;
    case (state_q)
      S_INIT: begin
        mem_addr_o  = cnt_q;
        mem_wr_en_o = ~rst;
      end
      S_RD0: begin
        mem_addr_o  = addr0;
        mem_rd_en_o = 1'b1;
      end
      S_RD1: begin
        mem_addr_o  = addr1;
        mem_rd_en_o = 1'b1;
      end
      S_WR: begin
        mem_addr_o  = way_q ? addr1 : addr0;
        mem_wdata_o = {1'b1, tag, ppn_q};
        mem_wr_en_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready_o  = (state_q == S_IDLE) & ~rst;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_hit_o   = hit_q;
  assign resp_ok_o    = ok_q;
  assign resp_way_o   = way_q;
  assign resp_ppn_o   = rppn_q;

endmodule

// File: tb/tb_cuckoo_walker.sv
// Bench for cuckoo_walker: behavioural page-table memory, table of
// lookup/insert vectors checked through an expected-response queue, plus
// hand sequences for init sweep, response back-pressure and mid-walk reset.
module tb_cuckoo_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [15:0] req_vpn = '0;
  logic [5:0]  req_ppn = '0;
  logic        resp_valid, resp_ready = 1'b1, resp_hit, resp_ok, resp_way;
  logic [5:0]  resp_ppn;
  logic [11:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        mem_wr_en, mem_rd_en;

  always #5 clk = ~clk;

  cuckoo_walker #(.INIT_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_vpn_i    (req_vpn),
    .req_ppn_i    (req_ppn),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_hit_o   (resp_hit),
    .resp_ok_o    (resp_ok),
    .resp_way_o   (resp_way),
    .resp_ppn_o   (resp_ppn),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_wr_en_o  (mem_wr_en),
    .mem_rd_en_o  (mem_rd_en)
  );

  // Page-table memory: read data one cycle after rd_en, output zeroed on writes.
  logic [11:0] mem [4096];
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= '0;
    end else if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
    end
  end

  logic [36:0] outs;
  assign outs = {req_ready, resp_valid, resp_hit, resp_ok, resp_way, resp_ppn,
                 mem_addr, mem_wdata, mem_wr_en, mem_rd_en};

  int n_vec = 0, n_bad = 0;

  // Port monitor, sampled mid-cycle.
  int          wr_n = 0, both_n = 0;
  logic [11:0] wr_a0, wr_a, wr_d;
  logic [11:0] rd_log[$];
  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (wr_n == 0) wr_a0 = mem_addr;
      wr_a = mem_addr;
      wr_d = mem_wdata;
      wr_n++;
    end
    if (mem_rd_en) rd_log.push_back(mem_addr);
    if (mem_rd_en && mem_wr_en) both_n++;
  end

  typedef struct {
    bit          op;
    logic [15:0] vpn;
    logic [5:0]  ppn;
    bit          hit, ok, chk_way, way;
    logic [5:0]  rppn;
    int          lat;
    logic [11:0] rd0, rd1;
    bit          wr;
    logic [11:0] wa, wd;
    bit          hold;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(bit op, logic [15:0] vpn, logic [5:0] ppn, bit hit,
                              bit ok, bit chk_way, bit way, logic [5:0] rppn,
                              int lat, logic [11:0] rd0, logic [11:0] rd1, bit wr,
                              logic [11:0] wa, logic [11:0] wd, bit hold);
    vec_t v;
    v.op = op; v.vpn = vpn; v.ppn = ppn; v.hit = hit; v.ok = ok;
    v.chk_way = chk_way; v.way = way; v.rppn = rppn; v.lat = lat;
    v.rd0 = rd0; v.rd1 = rd1; v.wr = wr; v.wa = wa; v.wd = wd; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int c;
    for (c = 0; c < 50 && !req_ready; c++) @(negedge clk);
    if (!req_ready) chk("req_ready_timeout", 0, 1);
  endtask

  task automatic init_wait(input string tag);
    int c;
    for (c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk({tag, "_ready_cycle"}, c, 4096);
    chk({tag, "_writes"}, wr_n, 4096);
    chk({tag, "_first_addr"}, wr_a0, 12'h000);
    chk({tag, "_last_addr"}, wr_a, 12'hFFF);
  endtask

  task automatic run_vec(input vec_t v);
    int   lat, nrd;
    vec_t e;
    exp_q.push_back(v);
    wait_ready();
    wr_n = 0;
    rd_log.delete();
    req_valid  = 1'b1;
    req_op     = v.op;
    req_vpn    = v.vpn;
    req_ppn    = v.ppn;
    resp_ready = !v.hold;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    e = exp_q.pop_front();
    chk($sformatf("latency_%h", e.vpn), lat, e.lat);
    if (lat == 0) begin
      resp_ready = 1'b1;
      return;
    end
    chk($sformatf("hit_%h", e.vpn), resp_hit, e.hit);
    chk($sformatf("ok_%h", e.vpn), resp_ok, e.ok);
    chk($sformatf("ppn_%h", e.vpn), resp_ppn, e.rppn);
    if (e.chk_way) chk($sformatf("way_%h", e.vpn), resp_way, e.way);
    nrd = (e.lat <= 4) ? 1 : 2;
    chk($sformatf("rd_count_%h", e.vpn), rd_log.size(), nrd);
    if (rd_log.size() >= 1) chk($sformatf("rd0_addr_%h", e.vpn), rd_log[0], e.rd0);
    if (rd_log.size() >= 2) chk($sformatf("rd1_addr_%h", e.vpn), rd_log[1], e.rd1);
    chk($sformatf("wr_count_%h", e.vpn), wr_n, e.wr ? 1 : 0);
    if (e.wr) begin
      chk($sformatf("wr_addr_%h", e.vpn), wr_a, e.wa);
      chk($sformatf("wr_data_%h", e.vpn), wr_d, e.wd);
    end
    if (e.hold) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk("resp_hold_stable", {resp_valid, req_ready, resp_hit, resp_ok, resp_way, resp_ppn},
            {1'b1, 1'b0, e.hit, e.ok, e.way, e.rppn});
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    chk("ready_after_resp", {req_ready, resp_valid}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom) | 12'h800;

    #2 chk("reset_outputs", outs, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    init_wait("init");

    //            op   vpn      ppn    hit ok cw way rppn  lat rd0     rd1     wr wa      wd      hold
    tbl.push_back(mk(0, 16'h1234, 6'h00, 0, 1, 0, 0, 6'h00, 5, 12'h234, 12'hAB0, 0, 12'h000, 12'h000, 0));
    tbl.push_back(mk(1, 16'h1234, 6'h15, 0, 1, 1, 0, 6'h00, 6, 12'h234, 12'hAB0, 1, 12'h234, 12'h895, 0));
    tbl.push_back(mk(0, 16'h1234, 6'h00, 1, 1, 1, 0, 6'h15, 3, 12'h234, 12'h000, 0, 12'h000, 12'h000, 0));
    tbl.push_back(mk(1, 16'h5234, 6'h2A, 0, 1, 1, 1, 6'h00, 6, 12'h234, 12'h8A0, 1, 12'h8A0, 12'hAAA, 0));
    tbl.push_back(mk(0, 16'h5234, 6'h00, 1, 1, 1, 1, 6'h2A, 5, 12'h234, 12'h8A0, 0, 12'h000, 12'h000, 0));
    tbl.push_back(mk(1, 16'h08A0, 6'h07, 0, 1, 1, 0, 6'h00, 6, 12'h0A0, 12'h8E3, 1, 12'h0A0, 12'h847, 0));
    tbl.push_back(mk(1, 16'h00A0, 6'h11, 0, 0, 0, 0, 6'h00, 5, 12'h0A0, 12'h8A0, 0, 12'h000, 12'h000, 0));
    tbl.push_back(mk(0, 16'h1234, 6'h00, 1, 1, 1, 0, 6'h15, 3, 12'h234, 12'h000, 0, 12'h000, 12'h000, 0));
    tbl.push_back(mk(0, 16'h08A0, 6'h00, 1, 1, 1, 0, 6'h07, 3, 12'h0A0, 12'h000, 0, 12'h000, 12'h000, 0));
    tbl.push_back(mk(0, 16'h00A0, 6'h00, 0, 1, 0, 0, 6'h00, 5, 12'h0A0, 12'h8A0, 0, 12'h000, 12'h000, 0));
    tbl.push_back(mk(0, 16'h5234, 6'h00, 1, 1, 1, 1, 6'h2A, 5, 12'h234, 12'h8A0, 0, 12'h000, 12'h000, 0));
    tbl.push_back(mk(1, 16'h1234, 6'h3F, 1, 1, 1, 0, 6'h00, 4, 12'h234, 12'h000, 1, 12'h234, 12'h8BF, 1));
    tbl.push_back(mk(0, 16'h1234, 6'h00, 1, 1, 1, 0, 6'h3F, 3, 12'h234, 12'h000, 0, 12'h000, 12'h000, 0));

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset while a lookup sits in CHK1 (cycle 4 after the handshake).
    wait_ready();
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_vpn   = 16'h00A0;
    req_ppn   = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rd1_before_rst", {mem_rd_en, mem_addr}, {1'b1, 12'h8A0});
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_mid_walk_outputs", outs, '0);
    wr_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    init_wait("reinit");

    // Table was swept again: a previously installed VPN now misses.
    run_vec(mk(0, 16'h1234, 6'h00, 0, 1, 0, 0, 6'h00, 5, 12'h234, 12'hAB0, 0, 12'h000, 12'h000, 0));

    chk("rd_wr_exclusive", both_n, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cuckoo_walker.md
# cuckoo_walker

Two-way cuckoo-hash walk engine sitting directly upstream of the 4096 x 12-bit page-table memory; it is that memory's only master. It accepts lookup and insert requests for a 16-bit virtual page number (VPN) and computes both candidate slots. It issues single-cycle reads and writes into the memory and returns the physical page number (PPN) or the insert status over a valid/ready response channel. After reset it sweeps the memory to zero so that every entry's valid bit is defined.

## Interface
- INIT_ON_RESET, 1: 1 = zero all 4096 entries after reset before accepting requests; 0 = skip the sweep (simulation only).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  walker idle and init complete; reset 0
- req_op  in  1  0 = lookup, 1 = insert
- req_vpn  in  16  virtual page number
- req_ppn  in  6  PPN to install (insert only)
- resp_valid  out  1  response present; reset 0
- resp_ready  in  1  consumer accepts response
- resp_hit  out  1  lookup found the VPN; insert found an existing VPN; reset 0
- resp_ok  out  1  insert wrote an entry; always 1 for lookup; reset 0
- resp_way  out  1  way that hit or was written; reset 0
- resp_ppn  out  6  translated PPN (lookup hit), else 0; reset 0
- mem_addr  out  12  memory address; reset 0
- mem_wdata  out  12  write data; reset 0
- mem_rdata  in  12  memory read data, valid the cycle after mem_rd_en
- mem_wr_en  out  1  write strobe; reset 0
- mem_rd_en  out  1  read strobe; reset 0

## Operation
- Entry format (12 bits): {valid[11], tag[10:6], ppn[5:0]}.
- tag = vpn[15:11]; h0 = vpn[10:0]; h1 = vpn[10:0] ^ {tag, tag, tag[0]}.
- Way 0 address = {1'b0, h0}; way 1 address = {1'b1, h1}.
- A slot matches when valid = 1 and tag == request tag.
- States: INIT, IDLE, RD0, CHK0, RD1, CHK1, WR, RESP.
- INIT: write 0 to address cnt, cnt from 0 to 4095, one write per cycle. Move to IDLE after address 4095. If INIT_ON_RESET = 0, the block enters IDLE directly.
- IDLE: req_ready = 1. On req_valid & req_ready, latch op, vpn and ppn, then go to RD0.
- RD0 / RD1: mem_rd_en = 1 and mem_addr = the way address, for one cycle.
- CHK0, lookup: a match gives hit/way0/ppn, then RESP. Otherwise go to RD1.
- CHK0, insert: a match leads to WR on way 0 (PPN update, hit = 1). Otherwise record whether way 0 is empty, then go to RD1.
- CHK1, lookup: a match gives hit/way1, then RESP. Otherwise miss (hit = 0, ppn = 0), then RESP.
- CHK1, insert: the first applicable rule wins.
  - Way 1 match: WR on way 1, hit = 1.
  - Way 0 empty: WR on way 0.
  - Way 1 empty: WR on way 1.
  - Otherwise: RESP with ok = 0.
  - There is no eviction or relocation.
- WR: mem_wr_en = 1, mem_wdata = {1, tag, req_ppn}, for one cycle, then RESP with ok = 1.
- RESP: response outputs held stable while resp_valid = 1 and resp_ready = 0. Go to IDLE on resp_ready.
- mem_rd_en and mem_wr_en are never asserted together.
- mem_rdata is ignored in every state except CHK0 and CHK1. The memory zeroes its output on writes, so its value elsewhere is not meaningful.

## Timing
- Request handshake in cycle 0.
- Lookup, way-0 hit: resp_valid from cycle 3.
- Lookup, way-1 hit or miss: resp_valid from cycle 5.
- Insert: WR in cycle 5, resp_valid from cycle 6.
- Insert update on way 0: WR in cycle 3, resp_valid from cycle 4.
- Insert failure: resp_valid from cycle 5.
- With resp_ready tied high, back-to-back throughput is 1 request per latency + 1 cycles. req_ready returns the cycle after the response handshake.
- Init sweep takes 4096 cycles; req_ready first rises in cycle 4096 after rst deasserts.
- rst asserted mid-walk or mid-write:
  - All outputs drop to reset values immediately and the in-flight request is discarded.
  - A write in flight may or may not land.
  - INIT restarts from address 0.

## Structure
- Shared package `cuckoo_pkg`:
  - Entry field positions and widths (TAG_W = 5, PPN_W = 6, IDX_W = 11).
  - State enum.
  - Op encoding.
  - Hash functions h0/h1 as functions, reused by future cuckoo stages.
- One sub-module, `cuckoo_hash`: combinational, vpn in, tag/addr0/addr1 out.
- FSM, init counter and response registers live in `cuckoo_walker`.

## Test plan
- After reset with INIT_ON_RESET = 1, the bench waits for req_ready. Lookup vpn 0x1234 -> reads 0x234 then 0xAB0, resp_hit = 0, ppn = 0, resp_valid at cycle 5.
- Insert vpn 0x1234 with ppn 0x15 -> writes 0x895 at address 0x234, ok = 1, way = 0. A following lookup -> hit = 1, ppn = 0x15, resp_valid at cycle 3.
- Insert 0x1234 (ppn 0x15), then 0x5234 with ppn 0x2A -> second write lands at 0x8A0 with data 0xAAA, way = 1. Lookup 0x5234 -> hit, way = 1, ppn = 0x2A.
- Insert 0x1234, then 0x5234, then 0x08A0 (way 0 at 0x0A0), then 0x00A0 -> ok = 0, no mem_wr_en pulse. Earlier entries remain intact.
- Re-insert 0x1234 with ppn 0x3F -> hit = 1, ok = 1, address 0x234 becomes 0x8BF. resp_ready held low 10 cycles -> outputs stable, no new req_ready.
- Assert rst during CHK1 of a lookup -> resp_valid, mem_rd_en and req_ready all 0 in the same cycle. The init sweep restarts at address 0.
